alu_arbiter: RTL and testbench

Shares the single combinational `alu` (32-bit operands, 4-bit opcode, negative/overflow/zero flags) between two requesters, e.g. the FPGA switch front-end and a debug/test sequencer. It arbitrates round-robin, registers the winning operands, runs the ALU for one cycle, and holds the registered result and flags until the owner accepts them. Each requester sees a valid/ready request channel and a valid/ready response channel.

---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/cpu_types_pkg.sv | 16 +
 rtl/alu.sv | 53 +++++
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Types and constants shared by the ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned REQ_N = 2;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  // Packs MSB-first as {negative, overflow, zero}.
  typedef struct packed {
    logic negative;
    logic overflow;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// CPU-wide shared types: ALU opcode encoding used by the alu and its clients.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLL = 4'h5,
    ALU_SRL = 4'h6,
    ALU_SRA = 4'h7,
    ALU_SLT = 4'h8
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result plus negative/overflow/zero flags.
module alu
  import cpu_types_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_t           op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              negative_o,
  output logic              overflow_o,
  output logic              zero_o
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign shamt = b_i[SH_W-1:0];
  assign sum   = a_i + b_i;
  assign diff  = a_i - b_i;

  // Opcode decode; signed overflow only meaningful for add/subtract.
  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o   = sum;
        overflow_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (sum[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_SUB: begin
        result_o   = diff;
        overflow_o = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff[DATA_W-1] != a_i[DATA_W-1]);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLL: result_o = a_i << shamt;
      ALU_SRL: result_o = a_i >> shamt;
      ALU_SRA: result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: result_o = '0;
    endcase
  end

  assign negative_o = result_o[DATA_W-1];
  assign zero_o     = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters.
// Operands are registered on grant, the ALU runs for one cycle, and the
// registered result is held until the owning requester accepts it.
module alu_arbiter
  import alu_arb_pkg::*, cpu_types_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REQ_N-1:0]  REQ_VALID,
  output logic [REQ_N-1:0]  REQ_READY,
  input  logic [DATA_W-1:0] REQ_A0,
  input  logic [DATA_W-1:0] REQ_B0,
  input  logic [DATA_W-1:0] REQ_A1,
  input  logic [DATA_W-1:0] REQ_B1,
  input  logic [3:0]        REQ_OP0,
  input  logic [3:0]        REQ_OP1,
  output logic [REQ_N-1:0]  RSP_VALID,
  input  logic [REQ_N-1:0]  RSP_READY,
  output logic [DATA_W-1:0] RSP_RESULT,
  output logic [2:0]        RSP_FLAGS,
  output logic              BUSY
);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  alu_op_t           op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  alu_flags_t        flags_q, flags_d;

  logic              gnt_any;
  logic              gnt_idx;
  logic [DATA_W-1:0] alu_result;
  logic              alu_neg, alu_ovf, alu_zero;

  // ALU sees only the operand registers, never the live request lines.
  alu #(.DATA_W(DATA_W)) u_alu (
    .a_i        (a_q),
    .b_i        (b_q),
    .op_i       (op_q),
    .result_o   (alu_result),
    .negative_o (alu_neg),
    .overflow_o (alu_ovf),
    .zero_o     (alu_zero)
  );

  // Grant pick: a lone requester always wins; on a tie, the one not served last.
  always_comb begin
    gnt_any = |REQ_VALID;
    if (REQ_VALID == 2'b11) gnt_idx = ~last_q;
    else                    gnt_idx = REQ_VALID[1];
  end

  // Next-state, register loads and handshake outputs.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    flags_d   = flags_q;
    REQ_READY = '0;
    RSP_VALID = '0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          REQ_READY[gnt_idx] = 1'b1;
          owner_d = gnt_idx;
          a_d     = gnt_idx ? REQ_A1 : REQ_A0;
          b_d     = gnt_idx ? REQ_B1 : REQ_B0;
          op_d    = alu_op_t'(gnt_idx ? REQ_OP1 : REQ_OP0);
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        flags_d  = '{negative: alu_neg, overflow: alu_ovf, zero: alu_zero};
        state_d  = RESP;
      end
      RESP: begin
        RSP_VALID[owner_q] = 1'b1;
        if (RSP_READY[owner_q]) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign RSP_RESULT = result_q;
  assign RSP_FLAGS  = flags_q;
  assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vector table, multi-cycle corner
// sequences and a randomized run against a transaction-level model.
module tb_alu_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  REQ_VALID = '0;
  logic [1:0]  REQ_READY;
  logic [31:0] REQ_A0 = '0, REQ_B0 = '0, REQ_A1 = '0, REQ_B1 = '0;
  logic [3:0]  REQ_OP0 = '0, REQ_OP1 = '0;
  logic [1:0]  RSP_VALID;
  logic [1:0]  RSP_READY = '0;
  logic [31:0] RSP_RESULT;
  logic [2:0]  RSP_FLAGS;
  logic        BUSY;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  alu_arbiter #(.DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_A0(REQ_A0), .REQ_B0(REQ_B0), .REQ_A1(REQ_A1), .REQ_B1(REQ_B1),
    .REQ_OP0(REQ_OP0), .REQ_OP1(REQ_OP1),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RESULT(RSP_RESULT), .RSP_FLAGS(RSP_FLAGS), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] r;
  } res_t;

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_r;
    logic [2:0]  exp_f;
  } vec_t;

  typedef struct {
    logic owner;
    res_t res;
  } sb_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  // Reference ALU from signed/unsigned arithmetic on wide integers.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    longint sa, sb, s;
    res_t   o;
    logic   v;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    v  = 1'b0;
    s  = 0;
    case (op)
      ALU_ADD: begin s = sa + sb; v = (s > SMAX) || (s < SMIN); end
      ALU_SUB: begin s = sa - sb; v = (s > SMAX) || (s < SMIN); end
      ALU_AND: s = longint'(a & b);
      ALU_OR:  s = longint'(a | b);
      ALU_XOR: s = longint'(a ^ b);
      ALU_SLL: s = longint'(a) * (64'sd1 << sh);
      ALU_SRL: s = longint'(a) / (64'sd1 << sh);
      ALU_SRA: s = sa >>> sh;
      ALU_SLT: s = (sa < sb) ? 1 : 0;
      default: s = 0;
    endcase
    o.r = s[31:0];
    o.f = {o.r[31], v, (o.r == 32'd0)};
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ_VALID = '0;
    RSP_READY = '0;
    tick();
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic drive(input int req, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    if (req == 0) begin REQ_A0 = a; REQ_B0 = b; REQ_OP0 = op; end
    else          begin REQ_A1 = a; REQ_B1 = b; REQ_OP1 = op; end
  endtask

  function automatic logic [31:0] rword();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One isolated transaction from IDLE, with latency and non-owner-ready checks.
  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    res_t       m;
    oh = (v.req == 0) ? 2'b01 : 2'b10;
    drive(v.req, v.a, v.b, v.op);
    REQ_VALID = oh;
    #1;
    chk("vec_req_ready", REQ_READY, oh);
    tick();
    REQ_VALID = '0;
    #1;
    chk("vec_exec_busy", {BUSY, RSP_VALID}, {1'b1, 2'b00});
    tick();
    chk("vec_rsp_valid", RSP_VALID, oh);
    chk("vec_result", RSP_RESULT, v.exp_r);
    chk("vec_flags", RSP_FLAGS, v.exp_f);
    m = model(v.a, v.b, v.op);
    chk("vec_model", {RSP_FLAGS, RSP_RESULT}, m);
    RSP_READY = ~oh;
    tick();
    chk("vec_nonowner_ignored", {RSP_VALID, RSP_RESULT}, {oh, v.exp_r});
    RSP_READY = oh;
    tick();
    chk("vec_back_idle", {BUSY, RSP_VALID}, {1'b0, 2'b00});
    RSP_READY = '0;
  endtask

  vec_t vecs[9];
  sb_t  sbq[$];

  initial begin
    int   start, n, last_acc;
    logic last_w;
    logic [1:0] acc, exp_g;
    int   nresp;

    vecs[0] = '{0, 32'd5,          32'd3,          ALU_ADD, 32'd8,          3'b000};
    vecs[1] = '{1, 32'd3,          32'd5,          ALU_SUB, 32'hFFFF_FFFE,  3'b100};
    vecs[2] = '{0, 32'h7FFF_FFFF,  32'd1,          ALU_ADD, 32'h8000_0000,  3'b110};
    vecs[3] = '{1, 32'd5,          32'd5,          ALU_SUB, 32'd0,          3'b001};
    vecs[4] = '{0, 32'h8000_0000,  32'd1,          ALU_SUB, 32'h7FFF_FFFF,  3'b010};
    vecs[5] = '{1, 32'h0000_F0F0,  32'h0000_0FF0,  ALU_AND, 32'h0000_00F0,  3'b000};
    vecs[6] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  ALU_XOR, 32'd0,          3'b001};
    vecs[7] = '{1, 32'hFFFF_FFFF,  32'd1,          ALU_SLT, 32'd1,          3'b000};
    vecs[8] = '{0, 32'h8000_0000,  32'd4,          ALU_SRA, 32'hF800_0000,  3'b100};

    // Reset state
    do_reset();
    chk("reset_outputs", {BUSY, RSP_VALID, REQ_READY, RSP_FLAGS}, '0);
    chk("reset_result", RSP_RESULT, 32'd0);

    // Directed table
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Both requesters valid from reset, response always accepted: 0,1,0,1 every 3 cycles
    do_reset();
    drive(0, 32'd1, 32'd2, ALU_ADD);
    drive(1, 32'd7, 32'd2, ALU_SUB);
    REQ_VALID = 2'b11;
    RSP_READY = 2'b11;
    #1;
    last_acc = 0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (REQ_READY == 2'b00 && n < 10) begin tick(); n++; end
      chk("alt_grant", REQ_READY, (g % 2 == 0) ? 2'b01 : 2'b10);
      if (g > 0) chk("alt_spacing", cyc - last_acc, 3);
      last_acc = cyc;
      tick();
    end
    REQ_VALID = '0;
    RSP_READY = '0;

    // Owner 0 backpressures for 10 cycles while requester 1 churns
    do_reset();
    drive(0, 32'd10, 32'd20, ALU_ADD);
    REQ_VALID = 2'b01;
    tick();
    REQ_VALID = 2'b11;
    drive(1, 32'd1, 32'd1, ALU_ADD);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1, $urandom, $urandom, 4'($urandom_range(0, 8)));
      #1;
      chk("bp_hold", {RSP_VALID, REQ_READY, RSP_FLAGS, RSP_RESULT}, {2'b01, 2'b00, 3'b000, 32'd30});
      tick();
    end
    RSP_READY = 2'b01;
    tick();
    RSP_READY = 2'b00;
    chk("bp_next_grant", REQ_READY, 2'b10);

    // Reset pulse in RESP drops the response and restores the tie-winner
    tick();
    REQ_VALID = 2'b00;
    tick();
    chk("rst_pre_resp", RSP_VALID, 2'b10);
    RST = 1'b1;
    #1;
    chk("rst_async_drop", {RSP_VALID, BUSY}, {2'b00, 1'b0});
    chk("rst_result_clear", RSP_RESULT, 32'd0);
    tick();
    RST = 1'b0;
    REQ_VALID = 2'b11;
    #1;
    chk("rst_tie_to_req0", REQ_READY, 2'b01);
    tick();
    REQ_VALID = 2'b00;
    RSP_READY = 2'b11;
    tick();
    tick();
    RSP_READY = 2'b00;

    // Randomized traffic checked against the transaction model
    do_reset();
    last_w = 1'b1;
    acc = '0;
    nresp = 0;
    start = 0;
    for (int c = 0; c < 430; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!REQ_VALID[i] || acc[i]) begin
          REQ_VALID[i] = (c < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
          drive(i, rword(), rword(), 4'($urandom_range(0, 8)));
        end
      end
      RSP_READY = (c < 400) ? 2'($urandom_range(0, 3)) : 2'b11;
      #1;
      if (BUSY)                    exp_g = 2'b00;
      else if (REQ_VALID == 2'b11) exp_g = last_w ? 2'b01 : 2'b10;
      else                         exp_g = REQ_VALID;
      chk("rand_req_ready", REQ_READY, exp_g);
      acc = REQ_VALID & REQ_READY;
      if (acc != 2'b00) begin
        if (acc[1]) sbq.push_back('{1'b1, model(REQ_A1, REQ_B1, REQ_OP1)});
        else        sbq.push_back('{1'b0, model(REQ_A0, REQ_B0, REQ_OP0)});
      end
      if (RSP_VALID != 2'b00) begin
        if (sbq.size() == 0) begin
          chk("rand_spurious_rsp", RSP_VALID, 2'b00);
        end else begin
          chk("rand_rsp_owner", RSP_VALID, sbq[0].owner ? 2'b10 : 2'b01);
          chk("rand_rsp_data", {RSP_FLAGS, RSP_RESULT}, sbq[0].res);
          if ((RSP_VALID & RSP_READY) != 2'b00) begin
            last_w = sbq[0].owner;
            void'(sbq.pop_front());
            nresp++;
          end
        end
      end
      tick();
    end
    chk("rand_drained", sbq.size(), 0);
    chk("rand_activity", (nresp > 20), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
